// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between Ctrl, the PC sequencer and InstROM.
// The master side drives the strobes and table writes; the slave side returns PC and status.
interface pc_sequencer_if #(
    parameter int PCW  = 10,
    parameter int OFFW = 8,
    parameter int LW   = 4,
    parameter int CTW  = 16
);
    logic            start;
    logic            halt;
    logic            branch_rel;
    logic [OFFW-1:0] offset;
    logic            branch_abs;
    logic            call;
    logic            ret;
    logic [LW-1:0]   lut_idx;
    logic            lut_we;
    logic [LW-1:0]   lut_waddr;
    logic [PCW-1:0]  lut_wdata;
    logic [PCW-1:0]  PC;
    logic            running;
    logic            done;
    logic            stack_ovf;
    logic            stack_unf;
    logic [CTW-1:0]  cycle_ct;

    modport master (
        output start, halt, branch_rel, offset, branch_abs, call, ret,
               lut_idx, lut_we, lut_waddr, lut_wdata,
        input  PC, running, done, stack_ovf, stack_unf, cycle_ct
    );

    modport slave (
        input  start, halt, branch_rel, offset, branch_abs, call, ret,
               lut_idx, lut_we, lut_waddr, lut_wdata,
        output PC, running, done, stack_ovf, stack_unf, cycle_ct
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: run-halt FSM, jump-target table, return stack,
// sticky stack error flags and a saturating RUN-cycle counter.
module pc_sequencer #(
    parameter int          PCW        = 10,
    parameter int          OFFW       = 8,
    parameter int          LUT_D      = 16,
    parameter int          STACK_D    = 4,
    parameter logic [PCW-1:0] START_ADDR = '0,
    parameter int          CTW        = 16
) (
    input logic            CLK,
    input logic            reset_n,
    pc_sequencer_if.slave  bus
);
    localparam int LW  = $clog2(LUT_D);
    localparam int SPW = $clog2(STACK_D + 1);
    localparam int SIW = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] table_q [LUT_D];
    logic [PCW-1:0] table_d [LUT_D];
    logic [PCW-1:0] stack_q [STACK_D];
    logic [PCW-1:0] stack_d [STACK_D];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [CTW-1:0] ct_q, ct_d;

    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] off_ext;
    logic [PCW-1:0] lut_rd;
    logic [SIW-1:0] top_idx;
    logic [SIW-1:0] push_idx;

    assign pc_inc   = pc_q + PCW'(1);
    assign off_ext  = PCW'($signed(bus.offset));
    // Table read sees the pre-write contents, giving read-before-write on a same-index collision.
    assign lut_rd   = table_q[bus.lut_idx];
    assign top_idx  = SIW'(sp_q - SPW'(1));
    assign push_idx = SIW'(sp_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        table_d = table_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ct_d    = ct_q;

        if (bus.start) begin
            state_d = RUN;
            pc_d    = START_ADDR;
            sp_d    = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            ct_d    = '0;
        end else if (state_q == RUN) begin
            if (ct_q != {CTW{1'b1}}) begin
                ct_d = ct_q + CTW'(1);
            end
            if (bus.halt) begin
                state_d = HALTED;
            end else if (bus.ret) begin
                if (sp_q != '0) begin
                    pc_d = stack_q[top_idx];
                    sp_d = sp_q - SPW'(1);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (bus.call) begin
                if (sp_q != SPW'(STACK_D)) begin
                    stack_d[push_idx] = pc_inc;
                    sp_d = sp_q + SPW'(1);
                    pc_d = lut_rd;
                end else begin
                    ovf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (bus.branch_abs) begin
                pc_d = lut_rd;
            end else if (bus.branch_rel) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end

        if (bus.lut_we) begin
            table_d[bus.lut_waddr] = bus.lut_wdata;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            table_q <= '{default: '0};
            stack_q <= '{default: '0};
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            table_q <= table_d;
            stack_q <= stack_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ct_q    <= ct_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.running   = (state_q == RUN);
    assign bus.done      = (state_q == HALTED);
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
    assign bus.cycle_ct  = ct_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, random run against a queue-based
// reference model, and a narrow-counter instance for saturation and async reset.
module tb_pc_sequencer;
    localparam int PCW = 10;
    localparam int OFFW = 8;
    localparam int LW = 4;
    localparam int CTW = 16;
    localparam int PCMOD = 1 << PCW;
    localparam int SDEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PCW(PCW), .OFFW(OFFW), .LW(LW), .CTW(CTW)) bus ();
    pc_sequencer_if #(.PCW(PCW), .OFFW(OFFW), .LW(LW), .CTW(4))   bus4 ();

    pc_sequencer #(.PCW(PCW), .OFFW(OFFW), .LUT_D(16), .STACK_D(SDEPTH),
                   .START_ADDR('0), .CTW(CTW))
        dut (.CLK(clk), .reset_n(reset_n), .bus(bus));

    pc_sequencer #(.PCW(PCW), .OFFW(OFFW), .LUT_D(16), .STACK_D(SDEPTH),
                   .START_ADDR('0), .CTW(4))
        dut4 (.CLK(clk), .reset_n(rst4_n), .bus(bus4));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic st, hl, rt, cl, ba, br;
        logic [7:0] off;
        logic [3:0] idx;
        logic we;
        logic [3:0] wa;
        logic [9:0] wd;
        int e_pc;
        int e_run, e_done, e_ovf, e_unf, e_ct;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(logic st, logic hl, logic rt, logic cl, logic ba, logic br,
                                logic [7:0] off, logic [3:0] idx, logic we, logic [3:0] wa,
                                logic [9:0] wd, int pc, int run, int dn, int ovf, int unf, int ct);
        vec_t v;
        v.st = st; v.hl = hl; v.rt = rt; v.cl = cl; v.ba = ba; v.br = br;
        v.off = off; v.idx = idx; v.we = we; v.wa = wa; v.wd = wd;
        v.e_pc = pc; v.e_run = run; v.e_done = dn; v.e_ovf = ovf; v.e_unf = unf; v.e_ct = ct;
        return v;
    endfunction

    // Reference model: plain integers, a queue for the stack, an array for the table.
    int m_pc, m_state, m_ct, m_ovf, m_unf;
    int m_tab[16];
    int m_stack[$];

    task automatic model_reset();
        m_pc = 0; m_state = 0; m_ct = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
        for (int i = 0; i < 16; i++) m_tab[i] = 0;
    endtask

    task automatic model_step();
        int tgt, nxt, off;
        tgt = m_tab[bus.lut_idx];
        nxt = (m_pc + 1) % PCMOD;
        off = $signed(bus.offset);
        if (bus.start) begin
            m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_ct = 0; m_state = 1;
        end else if (m_state == 1) begin
            if (m_ct < (1 << CTW) - 1) m_ct++;
            if (bus.halt) m_state = 2;
            else if (bus.ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_unf = 1; m_pc = nxt; end
            end else if (bus.call) begin
                if (m_stack.size() < SDEPTH) begin m_stack.push_back(nxt); m_pc = tgt; end
                else begin m_ovf = 1; m_pc = nxt; end
            end else if (bus.branch_abs) m_pc = tgt;
            else if (bus.branch_rel) m_pc = ((m_pc + off) % PCMOD + PCMOD) % PCMOD;
            else m_pc = nxt;
        end
        if (bus.lut_we) m_tab[bus.lut_waddr] = bus.lut_wdata;
    endtask

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_all(string tag, int pc, int run, int dn, int ovf, int unf, int ct);
        chk({tag, ".PC"}, int'(bus.PC), pc);
        chk({tag, ".running"}, int'(bus.running), run);
        chk({tag, ".done"}, int'(bus.done), dn);
        chk({tag, ".stack_ovf"}, int'(bus.stack_ovf), ovf);
        chk({tag, ".stack_unf"}, int'(bus.stack_unf), unf);
        chk({tag, ".cycle_ct"}, int'(bus.cycle_ct), ct);
    endtask

    task automatic drive(vec_t v);
        bus.start = v.st; bus.halt = v.hl; bus.ret = v.rt; bus.call = v.cl;
        bus.branch_abs = v.ba; bus.branch_rel = v.br; bus.offset = v.off;
        bus.lut_idx = v.idx; bus.lut_we = v.we; bus.lut_waddr = v.wa; bus.lut_wdata = v.wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    vec_t nop;

    initial begin
        nop = mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,0,0,0,0,0);
        drive(nop);
        bus4.start = 0; bus4.halt = 0; bus4.ret = 0; bus4.call = 0; bus4.branch_abs = 0;
        bus4.branch_rel = 0; bus4.offset = '0; bus4.lut_idx = '0; bus4.lut_we = 0;
        bus4.lut_waddr = '0; bus4.lut_wdata = '0;
        model_reset();

        // Directed table (columns: st hl rt cl ba br off idx we wa wd | pc run done ovf unf ct)
        vq.push_back(mk(0,0,0,1,0,1, 8'h05, 4'd0, 0, 4'd0, 10'h000, 0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,1,0,0,0,0));
        for (int i = 1; i <= 5; i++)
            vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, i,1,0,0,0,i));
        vq.push_back(mk(1,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,1,0,0,0,0));
        for (int i = 1; i <= 3; i++)
            vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, i,1,0,0,0,i));
        vq.push_back(mk(0,0,0,0,0,1, 8'hFB, 4'd0, 0, 4'd0, 10'h000, 1022,1,0,0,0,4));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 1023,1,0,0,0,5));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,1,0,0,0,6));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd2, 10'h155, 1,1,0,0,0,7));
        vq.push_back(mk(0,0,0,0,1,0, 8'h00, 4'd2, 0, 4'd0, 10'h000, 'h155,1,0,0,0,8));
        vq.push_back(mk(0,0,0,0,1,0, 8'h00, 4'd2, 1, 4'd2, 10'h0AA, 'h155,1,0,0,0,9));
        vq.push_back(mk(0,0,0,0,1,0, 8'h00, 4'd2, 0, 4'd0, 10'h000, 'h0AA,1,0,0,0,10));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd4, 10'd10, 'h0AB,1,0,0,0,11));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd5, 10'd20, 'h0AC,1,0,0,0,12));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd6, 10'd30, 'h0AD,1,0,0,0,13));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd7, 10'd40, 'h0AE,1,0,0,0,14));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd8, 10'd50, 'h0AF,1,0,0,0,15));
        vq.push_back(mk(0,0,0,0,1,0, 8'h00, 4'd4, 0, 4'd0, 10'h000, 10,1,0,0,0,16));
        vq.push_back(mk(0,0,0,1,0,0, 8'h00, 4'd5, 0, 4'd0, 10'h000, 20,1,0,0,0,17));
        vq.push_back(mk(0,0,0,1,0,0, 8'h00, 4'd6, 0, 4'd0, 10'h000, 30,1,0,0,0,18));
        vq.push_back(mk(0,0,0,1,0,0, 8'h00, 4'd7, 0, 4'd0, 10'h000, 40,1,0,0,0,19));
        vq.push_back(mk(0,0,0,1,0,0, 8'h00, 4'd8, 0, 4'd0, 10'h000, 50,1,0,0,0,20));
        vq.push_back(mk(0,0,0,1,0,0, 8'h00, 4'd4, 0, 4'd0, 10'h000, 51,1,0,1,0,21));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 41,1,0,1,0,22));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 31,1,0,1,0,23));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 21,1,0,1,0,24));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 11,1,0,1,0,25));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 12,1,0,1,1,26));
        vq.push_back(mk(1,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,1,0,0,0,0));
        for (int i = 1; i <= 7; i++)
            vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, i,1,0,0,0,i));
        vq.push_back(mk(0,1,0,1,0,0, 8'h00, 4'd4, 0, 4'd0, 10'h000, 7,0,1,0,0,8));
        vq.push_back(mk(0,0,0,1,0,1, 8'h10, 4'd4, 0, 4'd0, 10'h000, 7,0,1,0,0,8));
        vq.push_back(mk(0,0,0,0,0,0, 8'h00, 4'd0, 1, 4'd4, 10'h123, 7,0,1,0,0,8));
        vq.push_back(mk(1,0,0,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 0,1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1,0, 8'h00, 4'd4, 0, 4'd0, 10'h000, 'h123,1,0,0,0,1));
        vq.push_back(mk(0,0,1,0,0,0, 8'h00, 4'd0, 0, 4'd0, 10'h000, 'h124,1,0,0,1,2));

        // Reset state
        repeat (2) @(negedge clk);
        cmp_all("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        @(negedge clk);
        foreach (vq[k]) begin
            drive(vq[k]);
            tick();
            $display("vec %0d: PC=%0d run=%0d done=%0d ovf=%0d unf=%0d ct=%0d",
                     k, bus.PC, bus.running, bus.done, bus.stack_ovf, bus.stack_unf, bus.cycle_ct);
            cmp_all($sformatf("vec%0d", k), vq[k].e_pc, vq[k].e_run, vq[k].e_done,
                    vq[k].e_ovf, vq[k].e_unf, vq[k].e_ct);
        end

        // Random run against the reference model from a fresh reset
        drive(nop);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        bus.start = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            tick();
            $display("rnd %0d: PC=%0d model=%0d ct=%0d", n, bus.PC, m_pc, bus.cycle_ct);
            cmp_all($sformatf("rnd%0d", n), m_pc, int'(m_state == 1), int'(m_state == 2),
                    m_ovf, m_unf, m_ct);
            bus.start      = ($urandom_range(0, 39) == 0);
            bus.halt       = ($urandom_range(0, 29) == 0);
            bus.ret        = ($urandom_range(0, 5) == 0);
            bus.call       = ($urandom_range(0, 5) == 0);
            bus.branch_abs = ($urandom_range(0, 7) == 0);
            bus.branch_rel = ($urandom_range(0, 3) == 0);
            bus.offset     = 8'($urandom);
            bus.lut_idx    = 4'($urandom);
            bus.lut_we     = ($urandom_range(0, 3) == 0);
            bus.lut_waddr  = 4'($urandom);
            bus.lut_wdata  = 10'($urandom);
            if (m_state != 1 && $urandom_range(0, 7) == 0) bus.start = 1'b1;
        end

        // Narrow counter instance: saturation, then asynchronous reset mid-cycle
        @(negedge clk);
        rst4_n = 1'b1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        chk("ct4_after_start", int'(bus4.cycle_ct), 0);
        repeat (20) @(negedge clk);
        $display("ct4: PC=%0d ct=%0d", bus4.PC, bus4.cycle_ct);
        chk("ct4_pc", int'(bus4.PC), 20);
        chk("ct4_sat", int'(bus4.cycle_ct), 15);
        chk("ct4_running", int'(bus4.running), 1);
        @(posedge clk);
        #2;
        rst4_n = 1'b0;
        #1;
        $display("async reset: PC=%0d ct=%0d", bus4.PC, bus4.cycle_ct);
        chk("async_rst_pc", int'(bus4.PC), 0);
        chk("async_rst_ct", int'(bus4.cycle_ct), 0);
        chk("async_rst_running", int'(bus4.running), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and fetch sequencer for the next-generation core. It replaces the fixed 10-bit PC.
- Adds relative/absolute branching through a writable jump-target table, call/return via a return-address stack, run/halt state tracking and a saturating cycle counter.
- Sits between Ctrl (branch/call/ret/halt strobes) and InstROM (drives InstAddress).

Parameters:
- PCW, 10, PC / instruction address width.
- OFFW, 8, signed relative branch offset width (OFFW <= PCW).
- LUT_D, 16, jump-target table depth (power of 2); index width LW = $clog2(LUT_D).
- STACK_D, 4, return-address stack depth.
- START_ADDR, 0, PC value loaded on reset and on start.
- CTW, 16, cycle counter width.

Ports:
- CLK  in  1  clock, posedge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous re-init, active high.
- halt  in  1  done request from Ctrl.
- branch_rel  in  1  taken relative branch.
- offset  in  OFFW  signed relative offset.
- branch_abs  in  1  absolute jump to table[lut_idx].
- call  in  1  push return address, jump to table[lut_idx].
- ret  in  1  pop return address into PC.
- lut_idx  in  LW  jump-table read index.
- lut_we  in  1  jump-table write enable.
- lut_waddr  in  LW  jump-table write index.
- lut_wdata  in  PCW  jump-table write data.
- PC  out  PCW  current instruction address.
- running  out  1  high in RUN state.
- done  out  1  high in HALTED state.
- stack_ovf  out  1  sticky: call attempted with stack full.
- stack_unf  out  1  sticky: ret attempted with stack empty.
- cycle_ct  out  CTW  cycles spent in RUN, saturating.

Behaviour:
- Reset (reset_n low, async):
  - PC = START_ADDR; state IDLE; running = 0, done = 0; stack empty; stack_ovf = stack_unf = 0; cycle_ct = 0; all table entries = 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> HALTED on halt.
  - HALTED -> RUN on start.
  - start in any state: PC = START_ADDR, stack emptied, flags cleared, cycle_ct = 0, next state RUN. Table contents are preserved.
- PC update, RUN only, one per cycle, registered (new PC visible the cycle after the strobe). Priority: start > halt > ret > call > branch_abs > branch_rel > PC+1.
  - halt: PC holds. No further PC changes until start.
  - ret: non-empty stack pops the top into PC. Empty stack sets stack_unf and PC = PC+1.
  - call: non-full stack pushes PC+1 and sets PC = table[lut_idx]. Full stack sets stack_ovf, no push, PC = PC+1.
  - branch_abs: PC = table[lut_idx].
  - branch_rel: PC = PC + sign-extended offset, modulo 2^PCW (wrap both directions).
  - PC+1 wraps from 2^PCW-1 to 0.
- IDLE and HALTED: PC holds. Strobes other than start are ignored, except lut_we.
- Jump table:
  - Combinational read, synchronous write.
  - lut_we is honoured in every state.
  - Same-cycle write and read of the same index returns the old value (read-before-write).
- Stack is LIFO. The return value for ret is the top entry before the pop.
- cycle_ct increments each RUN cycle, including the halt cycle. Saturates at 2^CTW-1. Frozen in IDLE/HALTED.
- Flags are sticky until reset or start.
- reset_n asserted mid-run aborts immediately. Outputs take reset values asynchronously.

Test Plan:
- Reset, pulse start, run 5 cycles -> PC = 0,1,2,3,4,5; running = 1; cycle_ct = 5.
- PC = 3, branch_rel with offset = 8'hFB (-5), PCW = 10 -> PC = 10'd1022. Then 2 increments -> PC = 1022, 1023, 0 (wrap).
- Write table[2] = 10'h155, then branch_abs with lut_idx = 2 -> PC = 10'h155. Same-cycle lut_we to index 2 with 10'h0AA plus branch_abs idx 2 -> PC = 10'h155; the next access reads 10'h0AA.
- Nested calls: 4 calls from PC 10, 20, 30, 40 (table targets) -> fifth call sets stack_ovf and PC+1. Four rets -> PC = 41, 31, 21, 11. Fifth ret -> stack_unf = 1, PC increments.
- Simultaneous halt + call at PC = 7 -> PC stays 7, done = 1, stack unchanged, cycle_ct frozen. Start -> PC = START_ADDR, flags clear, RUN.
- CTW = 4: run 20 cycles -> cycle_ct saturates at 15. Drop reset_n mid-cycle -> PC = START_ADDR, cycle_ct = 0 immediately, without waiting for a clock edge.
